// File: rtl/master_out_port_pkg.sv
// master_out_port_pkg
//   Shared definitions for the serial master->slave link: default widths,
//   the transfer state encoding shared with the slave and return-path ports,
//   and a counter-width helper.
package master_out_port_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ceil(log2(v)), never less than 1 so every counter has at least one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/master_out_port_if.sv
// master_out_port_if
//   Serial link between master_out_port (master modport) and slave_in_port
//   (slave modport).
//   master_valid : request pending toward slave
//   slave_ready  : slave can accept a transfer
//   tx_address   : serial address bit, LSB first
//   tx_data      : serial write-data bit, LSB first
//   write_en     : write transfer in progress
//   read_en      : read transfer in progress
interface master_out_port_if;

    logic master_valid;
    logic slave_ready;
    logic tx_address;
    logic tx_data;
    logic write_en;
    logic read_en;

    modport master (
        output master_valid,
        output tx_address,
        output tx_data,
        output write_en,
        output read_en,
        input  slave_ready
    );

    modport slave (
        input  master_valid,
        input  tx_address,
        input  tx_data,
        input  write_en,
        input  read_en,
        output slave_ready
    );

endinterface

// File: rtl/master_out_port_piso_shift.sv
// piso_shift
//   Parallel-in serial-out shift register, LSB first, zero-filled from the top.
//   clk      : clock
//   reset    : asynchronous, active-high; clears the register
//   load     : capture din (has priority over shift_en)
//   shift_en : shift right by one
//   din      : parallel load value
//   sout     : current LSB
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift_en,
    input  logic [W-1:0] din,
    output logic         sout
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh <= '0;
        end else if (load) begin
            r_sh <= din;
        end else if (shift_en) begin
            r_sh <= r_sh >> 1;
        end
    end

    assign sout = r_sh[0];

endmodule

// File: rtl/master_out_port.sv
// master_out_port
//   Transmit side of the serial master->slave link. Captures a parallel
//   request, raises master_valid until slave_ready, then shifts address and
//   write data out LSB-first on two lines in parallel.
//   clk, reset         : clock, asynchronous active-high reset
//   req                : start transfer (sampled only in IDLE)
//   req_write          : 1 = write, 0 = read
//   addr_in, data_in   : request address / write data, captured with req
//   bus                : serial link, master modport
//   idle               : request will be accepted
//   tx_done            : one-cycle pulse after the last address bit
//   timeout            : one-cycle pulse when the request is abandoned
module master_out_port
    import master_out_port_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int unsigned READY_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    master_out_port_if.master     bus,
    output logic                  idle,
    output logic                  tx_done,
    output logic                  timeout
);

    localparam int unsigned CNT_W  = clog2_min1(ADDR_WIDTH);
    localparam int unsigned WAIT_W = clog2_min1(READY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((READY_TIMEOUT == 0) ? 0 : READY_TIMEOUT - 1);
    localparam bit                TIMEOUT_EN = (READY_TIMEOUT != 0);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_write;
    logic                r_timeout;

    logic                w_load;
    logic                w_shift;
    logic                w_handshake;
    logic                w_expire;
    logic                w_addr_bit;
    logic                w_data_bit;
    logic [DATA_WIDTH-1:0] w_data_load;

    assign w_load      = (r_state == ST_IDLE) && req;
    assign w_shift     = (r_state == ST_SEND);
    assign w_handshake = (r_state == ST_REQ) && bus.slave_ready;
    assign w_expire    = TIMEOUT_EN && (r_state == ST_REQ) && !bus.slave_ready
                         && (r_wait_cnt == WAIT_LAST);
    // reads load zeros so tx_data stays low for the whole transfer
    assign w_data_load = req_write ? data_in : '0;

    piso_shift #(.W(ADDR_WIDTH)) u_addr_sh (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .shift_en (w_shift),
        .din      (addr_in),
        .sout     (w_addr_bit)
    );

    piso_shift #(.W(DATA_WIDTH)) u_data_sh (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .shift_en (w_shift),
        .din      (w_data_load),
        .sout     (w_data_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (req) w_next = ST_REQ;
            ST_REQ: begin
                if (w_handshake) begin
                    w_next = ST_SEND;
                end else if (w_expire) begin
                    w_next = ST_IDLE;
                end
            end
            ST_SEND: if (r_bit_cnt == LAST_BIT) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_write    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            if (w_load) begin
                r_write <= req_write;
            end
            unique case (r_state)
                ST_REQ: begin
                    r_bit_cnt  <= '0;
                    r_wait_cnt <= w_handshake ? '0 : r_wait_cnt + 1'b1;
                end
                ST_SEND: begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_bit_cnt  <= '0;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        idle             = (r_state == ST_IDLE);
        bus.master_valid = (r_state == ST_REQ);
        bus.tx_address   = w_shift && w_addr_bit;
        bus.tx_data      = w_shift && w_data_bit;
        bus.write_en     = (r_state != ST_IDLE) && r_write;
        bus.read_en      = (r_state != ST_IDLE) && !r_write;
        tx_done          = (r_state == ST_DONE);
        timeout          = r_timeout;
    end

endmodule

// File: tb/tb_master_out_port.sv
// tb_master_out_port
//   Table-driven transfers on a wait-forever instance, expected serial bits
//   queued per transfer and checked by a monitor; hand-written sequences for
//   req-during-SEND, mid-transfer reset and the ready timeout instance.
`timescale 1ns/1ps
module tb_master_out_port;
    import master_out_port_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req, req_write;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          idle, tx_done, timeout;
    master_out_port_if bus();

    logic          t_req, t_req_write;
    logic [AW-1:0] t_addr_in;
    logic [DW-1:0] t_data_in;
    logic          t_idle, t_tx_done, t_timeout;
    master_out_port_if bus_to();

    master_out_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READY_TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .req(req), .req_write(req_write),
        .addr_in(addr_in), .data_in(data_in), .bus(bus),
        .idle(idle), .tx_done(tx_done), .timeout(timeout)
    );

    master_out_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READY_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .req(t_req), .req_write(t_req_write),
        .addr_in(t_addr_in), .data_in(t_data_in), .bus(bus_to),
        .idle(t_idle), .tx_done(t_tx_done), .timeout(t_timeout)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed { logic a; logic d; } bit_t;
    bit_t sb_q[$];

    // Monitor: a transfer starts on the first negedge where master_valid has
    // dropped while the port is not idle (handshake rather than timeout/reset).
    bit          mon_active = 0;
    bit          mon_prev_mv = 0;
    bit          mon_expect_done = 0;
    int unsigned mon_n = 0;

    always @(negedge clk) begin
        if (reset) begin
            mon_active      = 0;
            mon_prev_mv     = 0;
            mon_expect_done = 0;
            mon_n           = 0;
        end else begin
            if (mon_expect_done) begin
                chk("tx_done_pulse", 32'(tx_done), 32'd1);
                chk("done_lines", 32'({bus.tx_address, bus.tx_data}), 32'd0);
                mon_expect_done = 0;
            end else if (tx_done) begin
                chk("tx_done_spurious", 32'(tx_done), 32'd0);
            end
            if (!mon_active && mon_prev_mv && !bus.master_valid && !idle) begin
                mon_active = 1;
                mon_n      = 0;
            end
            if (mon_active) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL sb_underflow: bit %0d sent with no expected entry", mon_n);
                end else begin
                    bit_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("tx_address[%0d]", mon_n), 32'(bus.tx_address), 32'(e.a));
                    chk($sformatf("tx_data[%0d]", mon_n), 32'(bus.tx_data), 32'(e.d));
                end
                mon_n++;
                if (mon_n == AW) begin
                    mon_active      = 0;
                    mon_expect_done = 1;
                end
            end
            mon_prev_mv = bus.master_valid;
        end
    end

    task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int unsigned dly, input logic exp_we, input logic exp_re,
                           input int unsigned exp_vc, input bit glitch, input int rst_at);
        int unsigned vcnt;
        int          j;
        bit          done_seen;
        chk("idle_pre", 32'(idle), 32'd1);
        for (int k = 0; k < int'(AW); k++) begin
            bit_t e;
            e.a = a[k];
            e.d = (w && k < int'(DW)) ? d[k] : 1'b0;
            sb_q.push_back(e);
        end
        req = 1'b1; req_write = w; addr_in = a; data_in = d; bus.slave_ready = 1'b0;
        @(negedge clk);
        req = 1'b0; addr_in = ~a; data_in = ~d;
        chk("write_en", 32'(bus.write_en), 32'(exp_we));
        chk("read_en", 32'(bus.read_en), 32'(exp_re));
        vcnt = 0;
        while (bus.master_valid && vcnt < 64) begin
            bus.slave_ready = (vcnt >= dly);
            vcnt++;
            @(negedge clk);
        end
        bus.slave_ready = 1'b0;
        chk("valid_cycles", vcnt, exp_vc);
        chk("no_timeout", 32'(timeout), 32'd0);
        j = 0;
        done_seen = 0;
        while (!done_seen && j < 40) begin
            if (glitch && j == 3) begin
                req = 1'b1; req_write = ~w; addr_in = 12'h123; data_in = 8'h5A;
            end
            if (glitch && j == 4) req = 1'b0;
            if (rst_at >= 0 && j == rst_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_idle", 32'(idle), 32'd1);
                chk("rst_lines", 32'({bus.tx_address, bus.tx_data}), 32'd0);
                chk("rst_valid", 32'(bus.master_valid), 32'd0);
                chk("rst_en", 32'({bus.write_en, bus.read_en}), 32'd0);
                chk("rst_done", 32'(tx_done), 32'd0);
                sb_q.delete();
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            j++;
            if (tx_done) begin
                done_seen = 1;
                chk("we_in_done", 32'(bus.write_en), 32'(exp_we));
                chk("re_in_done", 32'(bus.read_en), 32'(exp_re));
            end
        end
        chk("tx_done_seen", 32'(done_seen), 32'd1);
        chk("done_latency", 32'(j), 32'(AW));
        @(negedge clk);
        chk("idle_post", 32'(idle), 32'd1);
        chk("en_post", 32'({bus.write_en, bus.read_en}), 32'd0);
        chk("valid_post", 32'(bus.master_valid), 32'd0);
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int unsigned   dly;
        logic          exp_we;
        logic          exp_re;
        int unsigned   exp_vc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned vcnt;
        logic        txact;

        vecs[0] = '{w:1'b1, a:12'hA5C, d:8'h3E, dly:0, exp_we:1'b1, exp_re:1'b0, exp_vc:1};
        vecs[1] = '{w:1'b0, a:12'hFFF, d:8'hFF, dly:0, exp_we:1'b0, exp_re:1'b1, exp_vc:1};
        vecs[2] = '{w:1'b1, a:12'h5A3, d:8'hC7, dly:5, exp_we:1'b1, exp_re:1'b0, exp_vc:6};
        vecs[3] = '{w:1'b1, a:12'h800, d:8'h81, dly:1, exp_we:1'b1, exp_re:1'b0, exp_vc:2};
        vecs[4] = '{w:1'b0, a:12'h001, d:8'h55, dly:2, exp_we:1'b0, exp_re:1'b1, exp_vc:3};

        reset = 1'b1; req = 1'b0; req_write = 1'b0; addr_in = '0; data_in = '0;
        bus.slave_ready = 1'b0;
        t_req = 1'b0; t_req_write = 1'b0; t_addr_in = '0; t_data_in = '0;
        bus_to.slave_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_outs", 32'({bus.master_valid, bus.tx_address, bus.tx_data, bus.write_en,
                               bus.read_en, tx_done, timeout}), 32'd0);
        chk("reset_to_idle", 32'(t_idle), 32'd1);
        chk("reset_to_outs", 32'({bus_to.master_valid, bus_to.tx_address, bus_to.tx_data,
                                  t_tx_done, t_timeout}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_xfer(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].dly,
                    vecs[i].exp_we, vecs[i].exp_re, vecs[i].exp_vc, 1'b0, -1);
        end

        // req pulsed during SEND with a different address must be ignored
        do_xfer(1'b1, 12'h3C5, 8'hA6, 0, 1'b1, 1'b0, 1, 1'b1, -1);
        @(negedge clk);
        chk("glitch_no_req", 32'(bus.master_valid), 32'd0);

        // reset asserted while bit 6 is on the lines
        do_xfer(1'b1, 12'h9B7, 8'h4D, 0, 1'b1, 1'b0, 1, 1'b0, 6);
        repeat (15) @(negedge clk);
        chk("post_rst_idle", 32'(idle), 32'd1);
        do_xfer(1'b1, 12'h2E1, 8'h93, 1, 1'b1, 1'b0, 2, 1'b0, -1);

        // ready never arrives on the timeout instance
        t_req = 1'b1; t_req_write = 1'b1; t_addr_in = 12'hABC; t_data_in = 8'hFF;
        bus_to.slave_ready = 1'b0;
        @(negedge clk);
        t_req = 1'b0;
        vcnt = 0;
        txact = 1'b0;
        while (bus_to.master_valid && vcnt < 64) begin
            vcnt++;
            txact = txact | bus_to.tx_address | bus_to.tx_data;
            @(negedge clk);
        end
        chk("to_valid_cycles", vcnt, 32'd4);
        chk("to_pulse", 32'(t_timeout), 32'd1);
        chk("to_idle", 32'(t_idle), 32'd1);
        chk("to_tx_quiet", 32'(txact), 32'd0);
        chk("to_en_off", 32'({bus_to.write_en, bus_to.read_en}), 32'd0);
        @(negedge clk);
        chk("to_pulse_width", 32'(t_timeout), 32'd0);
        chk("to_no_done", 32'(t_tx_done), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
